fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
Parametrised instruction fetch unit that replaces the single-shot fetch step. It generates sequential PCs and issues word requests over a req/gnt/rvalid memory handshake. Returned instructions are buffered with their PC in a FIFO of configurable depth and handed to decode over a valid/ready handshake. A redirect input lets execute or branch logic flush the queue and restart fetch at a new PC.

Parameters:
XLEN, 32, width of PC and memory address
RESET_PC, 32'h8000_0000, PC loaded on reset
QUEUE_DEPTH, 4, number of FIFO entries; power of two, >= 2
CNT_W, $clog2(QUEUE_DEPTH)+1, width of occupancy count (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
enable_i  in  1  fetch permitted; gates new requests only
redirect_i  in  1  flush and restart at redirect_pc_i (single-cycle pulse)
redirect_pc_i  in  XLEN  new fetch PC; bits [1:0] ignored
mem_req_o  out  1  memory request valid
mem_addr_o  out  XLEN  request address, word aligned
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  instruction word
dec_valid_o  out  1  queue head valid
dec_instr_o  out  32  head instruction
dec_pc_o  out  XLEN  head PC
dec_ready_i  in  1  decode accepts head
queue_count_o  out  CNT_W  current occupancy
fetch_busy_o  out  1  a request is pending or outstanding (state != IDLE)

Behaviour:
- Reset (async): pc=RESET_PC, FIFO empty, state=IDLE. Outputs: mem_req_o=0, mem_addr_o=RESET_PC, dec_valid_o=0, dec_instr_o=0, dec_pc_o=0, queue_count_o=0, fetch_busy_o=0. A reset in the middle of a transfer abandons it; any later rvalid is ignored.
- States: IDLE, REQ, WAIT_RESP, DROP_REQ, DROP_RESP. At most one request is outstanding.
- IDLE -> REQ when enable_i && !redirect_i && queue_count_o < QUEUE_DEPTH (registered count). The count check reserves a slot, so a push can never hit a full FIFO.
- REQ: mem_req_o=1 and mem_addr_o=pc. Address and req are held stable until mem_gnt_i. On gnt go to WAIT_RESP and set pc <= pc+4 (modulo 2^XLEN; wraps from 0xFFFF_FFFC to 0).
- WAIT_RESP: on mem_rvalid_i, push {pc_of_request, mem_rdata_i} and go to IDLE. mem_rvalid_i is guaranteed no earlier than the cycle after gnt.
- Latency: request enters REQ the cycle after the IDLE condition holds. Entry is visible on dec_* the cycle after rvalid. No bypass.
- dec_valid_o = (count != 0). Pop happens when dec_valid_o && dec_ready_i. Push and pop in the same cycle leave the count unchanged and preserve order.
- Redirect (priority over push, pop and issue):
  - FIFO is flushed; count is 0 next cycle. A same-cycle pop is void.
  - pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
  - In REQ without gnt: go to DROP_REQ. req and the old address are held until gnt, then go to DROP_RESP.
  - In REQ with gnt the same cycle, or in WAIT_RESP without rvalid: go to DROP_RESP.
  - In WAIT_RESP with rvalid the same cycle: data is discarded, go to IDLE.
  - In IDLE: stay in IDLE. Issue resumes the next cycle.
- DROP_RESP: the next rvalid is discarded (no push), then go to IDLE. A further redirect in DROP_* only updates pc.
- enable_i low: no new IDLE->REQ transition. Any in-flight request completes normally.
- queue_count_o ranges 0..QUEUE_DEPTH. Read and write pointers wrap modulo QUEUE_DEPTH.
- mem_addr_o = pc in every state except while holding a dropped request in DROP_REQ.

Test Plan:
- Release reset, enable_i=1, gnt immediate, rvalid 1 cycle later with 0x0000_0013 -> mem_addr_o=0x8000_0000; dec_valid_o=1, dec_pc_o=0x8000_0000 and dec_instr_o=0x13 one cycle after rvalid.
- dec_ready_i=0, DEPTH=4 -> entries for 0x8000_0000..0x8000_000C, queue_count_o=4, mem_req_o stays 0. Pulse dec_ready_i for 1 cycle -> count=3, next request at 0x8000_0010, FIFO order intact.
- Redirect to 0x8000_1002 in WAIT_RESP -> count=0 next cycle; pending rvalid data 0xDEAD_BEEF is never presented on dec_*; next request at 0x8000_1000.
- Redirect while mem_req_o=1, gnt withheld 3 cycles -> req and old address held until gnt, response dropped, then request at the redirect PC.
- Count=2 with simultaneous push and pop -> count stays 2; head advances to the second-oldest entry; new entry at tail.
- Assert rst_i asynchronously during WAIT_RESP -> outputs reset without a clock edge; a late rvalid is ignored; first post-reset request at 0x8000_0000.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Sequential instruction fetch with a single outstanding memory request and a
// PC-tagged instruction queue feeding decode; redirect flushes and restarts.
module fetch_queue_unit #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = 32'h8000_0000,
  parameter int               QUEUE_DEPTH = 4,
  localparam int              CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             mem_req_o,
  output logic [XLEN-1:0]  mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             dec_valid_o,
  output logic [31:0]      dec_instr_o,
  output logic [XLEN-1:0]  dec_pc_o,
  input  logic             dec_ready_i,
  output logic [CNT_W-1:0] queue_count_o,
  output logic             fetch_busy_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DROP_REQ,
    DROP_RESP
  } state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   req_pc_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;

  logic [31:0]       instr_mem [QUEUE_DEPTH];
  logic [XLEN-1:0]   pc_mem    [QUEUE_DEPTH];

  logic push, pop, has_room;

  assign has_room = (count_reg < CNT_W'(QUEUE_DEPTH));
  assign push     = (state_reg == WAIT_RESP) && mem_rvalid_i && !redirect_i;
  assign pop      = (count_reg != '0) && dec_ready_i && !redirect_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (enable_i && !redirect_i && has_room) state_next = REQ;
      end
      REQ: begin
        if (redirect_i)     state_next = mem_gnt_i ? DROP_RESP : DROP_REQ;
        else if (mem_gnt_i) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (mem_rvalid_i)    state_next = IDLE;
        else if (redirect_i) state_next = DROP_RESP;
      end
      DROP_REQ: begin
        if (mem_gnt_i) state_next = DROP_RESP;
      end
      DROP_RESP: begin
        if (mem_rvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // req_pc_reg tracks pc while requesting, so it keeps the issued address
  // both for tagging the response and for holding a dropped request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
    end else begin
      state_reg <= state_next;
      if (state_reg == REQ) req_pc_reg <= pc_reg;
      if (redirect_i)
        pc_reg <= {redirect_pc_i[XLEN-1:2], 2'b00};
      else if (state_reg == REQ && mem_gnt_i)
        pc_reg <= pc_reg + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (redirect_i) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= mem_rdata_i;
      pc_mem[wr_ptr_reg]    <= req_pc_reg;
    end
  end

  assign mem_req_o     = (state_reg == REQ) || (state_reg == DROP_REQ);
  assign mem_addr_o    = (state_reg == DROP_REQ) ? req_pc_reg : pc_reg;
  assign fetch_busy_o  = (state_reg != IDLE);
  assign queue_count_o = count_reg;
  assign dec_valid_o   = (count_reg != '0);
  // Gate the head so storage contents never leak out while the queue is empty.
  assign dec_instr_o   = dec_valid_o ? instr_mem[rd_ptr_reg] : 32'h0;
  assign dec_pc_o      = dec_valid_o ? pc_mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed per-cycle vector table plus hand sequences for push/pop overlap
// and asynchronous reset of fetch_queue_unit.
module tb_fetch_queue_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        dec_valid_o;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic        dec_ready_i = 1'b0;
  logic [2:0]  queue_count_o;
  logic        fetch_busy_o;

  int total = 0;
  int bad   = 0;

  fetch_queue_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .dec_valid_o   (dec_valid_o),
    .dec_instr_o   (dec_instr_o),
    .dec_pc_o      (dec_pc_o),
    .dec_ready_i   (dec_ready_i),
    .queue_count_o (queue_count_o),
    .fetch_busy_o  (fetch_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        en, redir;
    logic [31:0] rpc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc;
    logic [2:0]  e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic redir, logic [31:0] rpc, logic gnt, logic rv,
                              logic [31:0] rdata, logic rdy, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_instr, logic [31:0] e_pc,
                              logic [2:0] e_cnt, logic e_busy);
    vec_t v;
    v.en = en; v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic redir, input logic [31:0] rpc, input logic gnt,
                       input logic rv, input logic [31:0] rdata, input logic rdy);
    enable_i = en; redirect_i = redir; redirect_pc_i = rpc; mem_gnt_i = gnt;
    mem_rvalid_i = rv; mem_rdata_i = rdata; dec_ready_i = rdy;
  endtask

  task automatic cyc(input logic en, input logic redir, input logic [31:0] rpc, input logic gnt,
                     input logic rv, input logic [31:0] rdata, input logic rdy);
    drive(en, redir, rpc, gnt, rv, rdata, rdy);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // en redir rpc gnt rv rdata rdy | req addr valid instr pc cnt busy
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8000_0000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,1,32'h13,0, 0,32'h8000_0004,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0004,1,32'h13,32'h8000_0000,1,0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8000_0004,1,32'h13,32'h8000_0000,1,1));
    vecs.push_back(mk(1,0,0,0,1,32'hA1,0, 0,32'h8000_0008,1,32'h13,32'h8000_0000,1,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0008,1,32'h13,32'h8000_0000,2,0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8000_0008,1,32'h13,32'h8000_0000,2,1));
    vecs.push_back(mk(1,0,0,0,1,32'hA2,0, 0,32'h8000_000C,1,32'h13,32'h8000_0000,2,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_000C,1,32'h13,32'h8000_0000,3,0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8000_000C,1,32'h13,32'h8000_0000,3,1));
    vecs.push_back(mk(1,0,0,0,1,32'hA3,0, 0,32'h8000_0010,1,32'h13,32'h8000_0000,3,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0010,1,32'h13,32'h8000_0000,4,0));
    vecs.push_back(mk(1,0,0,0,0,0,1, 0,32'h8000_0010,1,32'h13,32'h8000_0000,4,0));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0010,1,32'hA1,32'h8000_0004,3,0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8000_0010,1,32'hA1,32'h8000_0004,3,1));
    vecs.push_back(mk(1,0,0,0,1,32'hA4,1, 0,32'h8000_0014,1,32'hA1,32'h8000_0004,3,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0014,1,32'hA2,32'h8000_0008,3,0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8000_0014,1,32'hA2,32'h8000_0008,3,1));
    vecs.push_back(mk(1,1,32'h8000_1002,0,0,0,0, 0,32'h8000_0018,1,32'hA2,32'h8000_0008,3,1));
    vecs.push_back(mk(1,0,0,0,1,32'hDEAD_BEEF,0, 0,32'h8000_1000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_1000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h8000_1000,0,0,0,0,1));
    vecs.push_back(mk(1,1,32'h8000_2000,0,0,0,0, 1,32'h8000_1000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h8000_1000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h8000_1000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h8000_1000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8000_1000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,1,32'hBAD0_BAD0,0, 0,32'h8000_2000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_2000,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8000_2000,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,0,1,32'h55,0, 0,32'h8000_2004,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h8000_2004,1,32'h55,32'h8000_2000,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h8000_2004,1,32'h55,32'h8000_2000,1,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFFE,0,0,0,0, 0,32'h8000_2004,1,32'h55,32'h8000_2000,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'hFFFF_FFFC,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0, 1,32'hFFFF_FFFC,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,1,32'h77,0, 0,32'h0000_0000,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h0000_0000,1,32'h77,32'hFFFF_FFFC,1,0));

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_addr", mem_addr_o, 32'h8000_0000);
    chk("rst_valid", 32'(dec_valid_o), 0);
    chk("rst_instr", dec_instr_o, 0);
    chk("rst_pc", dec_pc_o, 0);
    chk("rst_cnt", 32'(queue_count_o), 0);
    chk("rst_busy", 32'(fetch_busy_o), 0);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.en, v.redir, v.rpc, v.gnt, v.rv, v.rdata, v.rdy);
      chk($sformatf("v%0d_req", i), 32'(mem_req_o), 32'(v.e_req));
      chk($sformatf("v%0d_addr", i), mem_addr_o, v.e_addr);
      chk($sformatf("v%0d_valid", i), 32'(dec_valid_o), 32'(v.e_valid));
      chk($sformatf("v%0d_cnt", i), 32'(queue_count_o), 32'(v.e_cnt));
      chk($sformatf("v%0d_busy", i), 32'(fetch_busy_o), 32'(v.e_busy));
      if (v.e_valid) begin
        chk($sformatf("v%0d_instr", i), dec_instr_o, v.e_instr);
        chk($sformatf("v%0d_pc", i), dec_pc_o, v.e_pc);
      end
      $display("vec %0d: req=%0b addr=%h valid=%0b instr=%h pc=%h cnt=%0d busy=%0b",
               i, mem_req_o, mem_addr_o, dec_valid_o, dec_instr_o, dec_pc_o, queue_count_o,
               fetch_busy_o);
      @(posedge clk_i);
      #1;
    end

    // Push and pop together at count 2
    cyc(1,0,0,0,0,0,0);
    cyc(1,0,0,1,0,0,0);
    cyc(0,0,0,0,1,32'h88,0);
    chk("pp_cnt_before", 32'(queue_count_o), 2);
    cyc(1,0,0,0,0,0,0);
    cyc(0,0,0,1,0,0,0);
    chk("pp_head_before", dec_instr_o, 32'h77);
    cyc(0,0,0,0,1,32'h99,1);
    chk("pp_cnt_after", 32'(queue_count_o), 2);
    chk("pp_head_instr", dec_instr_o, 32'h88);
    chk("pp_head_pc", dec_pc_o, 32'h0000_0000);
    cyc(0,0,0,0,0,0,1);
    chk("pp_tail_instr", dec_instr_o, 32'h99);
    chk("pp_tail_pc", dec_pc_o, 32'h0000_0004);
    chk("pp_tail_cnt", 32'(queue_count_o), 1);
    $display("pushpop: cnt=%0d instr=%h pc=%h", queue_count_o, dec_instr_o, dec_pc_o);

    // Asynchronous reset while waiting for a response
    cyc(1,0,0,0,0,0,0);
    cyc(1,0,0,1,0,0,0);
    chk("ar_busy_before", 32'(fetch_busy_o), 1);
    drive(0,0,0,0,0,0,0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar_req", 32'(mem_req_o), 0);
    chk("ar_addr", mem_addr_o, 32'h8000_0000);
    chk("ar_valid", 32'(dec_valid_o), 0);
    chk("ar_instr", dec_instr_o, 0);
    chk("ar_pc", dec_pc_o, 0);
    chk("ar_cnt", 32'(queue_count_o), 0);
    chk("ar_busy", 32'(fetch_busy_o), 0);
    cyc(0,0,0,0,1,32'hEE,0);
    rst_i = 1'b0;
    cyc(0,0,0,0,1,32'hEE,0);
    chk("ar_late_cnt", 32'(queue_count_o), 0);
    chk("ar_late_busy", 32'(fetch_busy_o), 0);
    cyc(1,0,0,0,0,0,0);
    chk("ar_first_req", 32'(mem_req_o), 1);
    chk("ar_first_addr", mem_addr_o, 32'h8000_0000);
    $display("async reset: req=%0b addr=%h cnt=%0d", mem_req_o, mem_addr_o, queue_count_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
